enemy_formation_mover: RTL and testbench

- Parametrised successor to the single-enemy bouncing mover. Moves a row of N enemies horizontally as one formation on a tick derived from the 50 MHz clock.
- The formation bounces at the screen bounds, judged on the leftmost and rightmost *alive* enemy. Each bounce drops the formation by a fixed step.
- Sits between game control (start, pause, alive mask from collision logic) and the sprite renderer (per-enemy x and shared y).

---
 rtl/enemy_formation_mover_pkg.sv | 22 ++
 rtl/enemy_formation_mover_tick_divider.sv | 36 +++
 rtl/enemy_formation_mover.sv | 209 ++++++++++++++++++++
 tb/tb_enemy_formation_mover.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_formation_mover_pkg.sv
// Shared mover types and screen geometry (160x120), reused by the enemy, player and bullet movers.
// Holds the mover state encoding and the divider reload helper used when the formation speeds up.
package enemy_formation_mover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } mover_state_e;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  // Divider reload after `shift` speed-ups; never below one cycle per tick.
  function automatic int unsigned reload_for(input int unsigned div, input int unsigned shift);
    int unsigned r;
    r = div >> shift;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/enemy_formation_mover_tick_divider.sv
// Reloadable down-counter: tick is high while the count sits at zero and enabled; count then reloads.
// A synchronous load restarts the period and masks that cycle's tick; en=0 holds the count.
module tick_divider #(
  parameter int unsigned      CNT_W     = 22,
  parameter logic [CNT_W-1:0] RESET_CNT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] reload_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = reload_val - CNT_W'(1);
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? reload_val - CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  assign tick = en && !load && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RESET_CNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enemy_formation_mover.sv
// Moves a row of N enemies as one formation, bouncing on the outermost alive slots and dropping per bounce.
// Positions update the cycle after a divider tick; ENEMY_SPEEDUP_EN shortens the tick period per bounce.
module enemy_formation_mover
  import enemy_formation_mover_pkg::*;
#(
  parameter int unsigned N_ENEMIES = 4,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = SCREEN_W - 1,
  parameter int unsigned Y_START   = 0,
  parameter int unsigned Y_MAX     = 100,
  parameter int unsigned SPACING   = 16,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DROP      = 4,
  parameter int unsigned TICK_DIV  = 2_500_000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     enable,
  input  logic [N_ENEMIES-1:0]     alive,
  output logic [N_ENEMIES*X_W-1:0] x_out,
  output logic [Y_W-1:0]           y_out,
  output logic                     moving_left,
  output logic                     tick,
  output logic                     bounced,
  output logic                     reached_bottom,
  output logic                     formation_clear
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
  localparam int unsigned IDX_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
  localparam int unsigned XW1   = X_W + 1;
  localparam int unsigned YW1   = Y_W + 1;

  mover_state_e state_q, state_d;
  logic [X_W-1:0]           base_q, base_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic                     left_q, left_d;
  logic                     bounced_q, bounced_d;
  logic                     bottom_q, bottom_d;
  logic                     tick_q;
  logic [N_ENEMIES*X_W-1:0] x_q, x_d;

  logic             div_en, div_tick;
  logic [CNT_W-1:0] reload;

  logic [IDX_W-1:0] lo_idx, hi_idx;
  logic [X_W-1:0]   lo_off, hi_off, l_edge, r_edge;
  logic             hit_left, hit_right;
  logic [YW1-1:0]   y_sum;

  assign div_en = enable && (state_q != ST_IDLE);

  tick_divider #(
    .CNT_W     (CNT_W),
    .RESET_CNT (CNT_W'(TICK_DIV - 1))
  ) u_tick_divider (
    .clk        (clock),
    .rst_n      (resetn),
    .en         (div_en),
    .load       (start),
    .reload_val (reload),
    .tick       (div_tick)
  );

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = int'(N_ENEMIES) - 1; i >= 0; i--) begin
      if (alive[i]) lo_idx = IDX_W'(i);
    end
    for (int i = 0; i < int'(N_ENEMIES); i++) begin
      if (alive[i]) hi_idx = IDX_W'(i);
    end
  end

  // Edges wrap modulo 2^X_W like the slot outputs; a live edge is always on screen, so the
  // one-bit-wider compares below see its true value.
  assign lo_off    = X_W'(SPACING * lo_idx);
  assign hi_off    = X_W'(SPACING * hi_idx);
  assign l_edge    = base_q + lo_off;
  assign r_edge    = base_q + hi_off;
  assign hit_right = ({1'b0, r_edge} + XW1'(STEP)) > XW1'(X_MAX);
  assign hit_left  = {1'b0, l_edge} < XW1'(X_MIN + STEP);
  assign y_sum     = {1'b0, y_q} + YW1'(DROP);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    y_d       = y_q;
    left_d    = left_q;
    bounced_d = 1'b0;
    bottom_d  = bottom_q;
    if (start) begin
      state_d  = ST_RUN;
      base_d   = X_W'(X_MIN);
      y_d      = Y_W'(Y_START);
      left_d   = 1'b0;
      bottom_d = 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (div_tick && (alive != '0)) begin
            if (!left_q) begin
              if (hit_right) begin
                base_d    = X_W'(X_MAX) - hi_off;
                left_d    = 1'b1;
                bounced_d = 1'b1;
                state_d   = ST_DROP;
              end else begin
                base_d = base_q + X_W'(STEP);
              end
            end else begin
              if (hit_left) begin
                base_d    = X_W'(X_MIN) - lo_off;
                left_d    = 1'b0;
                bounced_d = 1'b1;
                state_d   = ST_DROP;
              end else begin
                base_d = base_q - X_W'(STEP);
              end
            end
          end
        end
        ST_DROP: begin
          if (y_sum >= YW1'(Y_MAX)) begin
            y_d      = Y_W'(Y_MAX);
            bottom_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            y_d     = y_sum[Y_W-1:0];
            state_d = ST_RUN;
          end
        end
        ST_HALT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    x_d = '0;
    for (int i = 0; i < int'(N_ENEMIES); i++) begin
      x_d[i*X_W +: X_W] = base_d + X_W'(SPACING * i);
    end
  end

`ifdef ENEMY_SPEEDUP_EN
  logic [1:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (start) begin
      bcnt_d = 2'd0;
    end else if (bounced_d && (bcnt_q != 2'd3)) begin
      bcnt_d = bcnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bcnt_q <= 2'd0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  // The reload taken on a bouncing tick already uses the new, faster period.
  assign reload = CNT_W'(reload_for(TICK_DIV, {30'd0, bcnt_d}));
`else
  assign reload = CNT_W'(TICK_DIV);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      base_q    <= X_W'(X_MIN);
      y_q       <= Y_W'(Y_START);
      left_q    <= 1'b0;
      bounced_q <= 1'b0;
      bottom_q  <= 1'b0;
      tick_q    <= 1'b0;
      for (int i = 0; i < int'(N_ENEMIES); i++) begin
        x_q[i*X_W +: X_W] <= X_W'(X_MIN + SPACING * i);
      end
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      y_q       <= y_d;
      left_q    <= left_d;
      bounced_q <= bounced_d;
      bottom_q  <= bottom_d;
      tick_q    <= div_tick;
      x_q       <= x_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign moving_left     = left_q;
  assign tick            = tick_q;
  assign bounced         = bounced_q;
  assign reached_bottom  = bottom_q;
  assign formation_clear = (alive == '0);

endmodule

// File: tb/tb_enemy_formation_mover.sv
// Scoreboard bench: a behavioural formation model pushes the expected slots per tick; DUT ticks pop them.
module tb_enemy_formation_mover;

  logic        clock = 1'b0;
  logic        resetn, start, enable;
  logic [3:0]  alive;
  logic [31:0] x_out;
  logic [6:0]  y_out;
  logic        moving_left, tick, bounced, reached_bottom, formation_clear;

  always #5 clock = ~clock;

  enemy_formation_mover #(
    .N_ENEMIES (4), .X_W (8), .Y_W (7), .X_MIN (0), .X_MAX (159),
    .Y_START (0), .Y_MAX (10), .SPACING (16), .STEP (1), .DROP (4), .TICK_DIV (4)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .enable          (enable),
    .alive           (alive),
    .x_out           (x_out),
    .y_out           (y_out),
    .moving_left     (moving_left),
    .tick            (tick),
    .bounced         (bounced),
    .reached_bottom  (reached_bottom),
    .formation_clear (formation_clear)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] x;
    logic        left;
    logic        bnc;
  } exp_t;

  exp_t sb[$];

  int m_base, m_y;
  bit m_left, m_bottom;

  localparam logic [31:0] HOME_X = {8'd48, 8'd32, 8'd16, 8'd0};

  function automatic void model_start();
    m_base = 0; m_y = 0; m_left = 0; m_bottom = 0;
  endfunction

  function automatic void model_tick(input logic [3:0] msk);
    exp_t e;
    int lo, hi;
    bit b;
    b = 0; lo = -1; hi = -1;
    for (int i = 0; i < 4; i++) if (msk[i]) begin if (lo < 0) lo = i; hi = i; end
    if (hi >= 0) begin
      if (!m_left) begin
        if (m_base + 16 * hi + 1 > 159) begin m_base = 159 - 16 * hi; m_left = 1; b = 1; end
        else m_base = m_base + 1;
      end else begin
        if (m_base + 16 * lo - 1 < 0) begin m_base = -16 * lo; m_left = 0; b = 1; end
        else m_base = m_base - 1;
      end
    end
    if (b) begin
      m_y = (m_y + 4 > 10) ? 10 : m_y + 4;
      m_bottom = (m_y == 10);
    end
    for (int i = 0; i < 4; i++) e.x[i*8 +: 8] = 8'((m_base + 16 * i) & 255);
    e.left = m_left;
    e.bnc  = b;
    sb.push_back(e);
  endfunction

  // Predict one movement, wait for the DUT's tick (bounded), then pop and compare.
  task automatic check_tick(input string tag, input int exp_n, output bit bnc);
    exp_t e;
    int n;
    model_tick(alive);
    n = 0;
    do begin @(negedge clock); n++; end while (tick !== 1'b1 && n < 64);
    e = sb.pop_front();
    bnc = e.bnc;
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL %s tick: none within %0d cycles, required a pulse", tag, n);
      return;
    end
    if (exp_n > 0) begin
      vectors++;
      if (n !== exp_n) begin
        miscompares++;
        $display("FAIL %s tick_period: got %0d cycles, required %0d", tag, n, exp_n);
      end
    end
    vectors++;
    if (x_out !== e.x) begin
      miscompares++;
      $display("FAIL %s x_out: got %h, required %h", tag, x_out, e.x);
    end
    vectors++;
    if (moving_left !== e.left) begin
      miscompares++;
      $display("FAIL %s moving_left: got %b, required %b", tag, moving_left, e.left);
    end
    vectors++;
    if (bounced !== e.bnc) begin
      miscompares++;
      $display("FAIL %s bounced: got %b, required %b", tag, bounced, e.bnc);
    end
  endtask

  task automatic check_drop(input string tag);
    @(negedge clock);
    vectors++;
    if (y_out !== 7'(m_y)) begin
      miscompares++;
      $display("FAIL %s y_out: got %0d, required %0d", tag, y_out, m_y);
    end
    vectors++;
    if (reached_bottom !== m_bottom) begin
      miscompares++;
      $display("FAIL %s reached_bottom: got %b, required %b", tag, reached_bottom, m_bottom);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    model_start();
  endtask

  task automatic run_until_bounce(input string tag, input int first_n, output bit bnc);
    int k;
    bnc = 0; k = 0;
    while (!bnc && k < 300) begin
      check_tick(tag, (k == 0) ? first_n : 4, bnc);
      k++;
    end
    vectors++;
    if (!bnc) begin
      miscompares++;
      $display("FAIL %s bounce: none after %0d ticks, required one", tag, k);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; enable = 1'b1; alive = 4'hF;
    repeat (3) @(negedge clock);
    vectors++;
    if (x_out !== HOME_X || y_out !== 7'd0 || moving_left !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pos: got x=%h y=%0d left=%b, required x=%h y=0 left=0", x_out, y_out, moving_left, HOME_X);
    end
    vectors++;
    if (tick !== 1'b0 || bounced !== 1'b0 || reached_bottom !== 1'b0 || formation_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got tick=%b bnc=%b bottom=%b clear=%b, required all 0", tick, bounced, reached_bottom, formation_clear);
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      vectors++;
      if (tick !== 1'b0 || x_out !== HOME_X) begin
        miscompares++;
        $display("FAIL idle_hold: got tick=%b x=%h, required tick=0 x=%h", tick, x_out, HOME_X);
      end
    end
  endtask

  task automatic test_start();
    bit bnc;
    do_start();
    vectors++;
    if (x_out !== HOME_X || y_out !== 7'd0 || moving_left !== 1'b0) begin
      miscompares++;
      $display("FAIL start_pos: got x=%h y=%0d left=%b, required x=%h y=0 left=0", x_out, y_out, moving_left, HOME_X);
    end
    check_tick("first_tick", 4, bnc);
  endtask

  task automatic test_bounce_right();
    bit bnc;
    run_until_bounce("run_right", 4, bnc);
    vectors++;
    if (x_out[7:0] !== 8'd111) begin
      miscompares++;
      $display("FAIL right_bounce_base: got %0d, required 111", x_out[7:0]);
    end
    check_drop("drop1");
  endtask

  task automatic test_enable_freeze();
    bit bnc;
    logic [31:0] xs;
    logic [6:0]  ys;
    xs = x_out; ys = y_out;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      vectors++;
      if (tick !== 1'b0 || x_out !== xs || y_out !== ys) begin
        miscompares++;
        $display("FAIL freeze: got tick=%b x=%h y=%0d, required tick=0 x=%h y=%0d", tick, x_out, y_out, xs, ys);
      end
    end
    enable = 1'b1;
    check_tick("resume", 3, bnc);
  endtask

  task automatic test_single_alive();
    bit bnc;
    alive = 4'b0001;
    run_until_bounce("single_left", 4, bnc);
    vectors++;
    if (x_out[7:0] !== 8'd0) begin
      miscompares++;
      $display("FAIL left_bounce_base: got %0d, required 0", x_out[7:0]);
    end
    check_drop("drop2");
    run_until_bounce("single_right", 0, bnc);
    vectors++;
    if (x_out[7:0] !== 8'd159) begin
      miscompares++;
      $display("FAIL deferred_right_base: got %0d, required 159", x_out[7:0]);
    end
    check_drop("drop3");
  endtask

  task automatic test_halt_restart();
    logic [31:0] xs;
    xs = x_out;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      vectors++;
      if (x_out !== xs || y_out !== 7'd10 || reached_bottom !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_hold: got x=%h y=%0d bottom=%b, required x=%h y=10 bottom=1", x_out, y_out, reached_bottom, xs);
      end
    end
    do_start();
    vectors++;
    if (x_out !== HOME_X || y_out !== 7'd0 || reached_bottom !== 1'b0 || moving_left !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_restart: got x=%h y=%0d bottom=%b left=%b, required x=%h y=0 bottom=0 left=0", x_out, y_out, reached_bottom, moving_left, HOME_X);
    end
  endtask

  task automatic test_clear();
    bit bnc;
    alive = 4'b0000;
    #1;
    vectors++;
    if (formation_clear !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_level: got %b, required 1", formation_clear);
    end
    for (int i = 0; i < 3; i++) check_tick("clear_tick", 4, bnc);
    alive = 4'b1111;
    #1;
    vectors++;
    if (formation_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_release: got %b, required 0", formation_clear);
    end
    for (int i = 0; i < 2; i++) check_tick("clear_resume", 4, bnc);
  endtask

  task automatic test_start_on_tick();
    bit bnc;
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    vectors++;
    if (tick !== 1'b0 || x_out !== HOME_X) begin
      miscompares++;
      $display("FAIL start_masks_tick: got tick=%b x=%h, required tick=0 x=%h", tick, x_out, HOME_X);
    end
    start = 1'b0;
    model_start();
    check_tick("after_start", 4, bnc);
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce_right();
    test_enable_freeze();
    test_single_alive();
    test_halt_restart();
    test_clear();
    test_start_on_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
